// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Step/mask helpers keep the dual-slot alignment rule in one place.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        PC_NA     = 2'b00,
        PC_NORMAL = 2'b01,
        PC_JUMP   = 2'b10,
        PC_BRANCH = 2'b11
    } pc_ctrl_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_STEP_1 = 32'd4;
    localparam logic [31:0] FETCH_STEP_2 = 32'd8;

    // A dual fetch is only possible from an 8-byte aligned address.
    function automatic logic [31:0] fetch_step(input logic addr_b2, input int width);
        return (width == 2 && !addr_b2) ? FETCH_STEP_2 : FETCH_STEP_1;
    endfunction

    function automatic logic [1:0] fetch_mask(input logic addr_b2, input int width);
        return (width == 2 && !addr_b2) ? 2'b11 : 2'b01;
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch request channel between the PC sequencer (master) and IMEM (slave).
interface fetch_pc_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_slot_mask;
    logic        req_epoch;

    modport master (
        output req_valid, req_addr, req_slot_mask, req_epoch,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_slot_mask, req_epoch,
        output req_ready
    );
endinterface

// File: rtl/fetch_pc_sequencer_kogge_stone.sv
// Codebase Kogge-Stone parallel-prefix adder/subtractor.
// sub_en=1 computes a-b via two's complement (carry-in of 1).
module Kogge_Stone #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_en,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0]             b_eff;
    logic [WIDTH-1:0]             p0;
    logic [LEVELS:0][WIDTH-1:0]   gk;
    logic [LEVELS:0][WIDTH-1:0]   pk;
    logic [WIDTH:0]               carry;
    logic                         unused_pk;

    assign b_eff = b ^ {WIDTH{sub_en}};
    assign p0    = a ^ b_eff;

    always_comb begin
        gk = '0;
        pk = '0;
        gk[0] = a & b_eff;
        // Fold carry-in into bit 0 so the prefix tree needs no extra column.
        gk[0][0] = gk[0][0] | (p0[0] & sub_en);
        pk[0] = p0;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
                    pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
                end else begin
                    gk[l+1][i] = gk[l][i];
                    pk[l+1][i] = pk[l][i];
                end
            end
        end
    end

    assign carry     = {gk[LEVELS], sub_en};
    assign sum       = p0 ^ carry[WIDTH-1:0];
    assign cout      = carry[WIDTH];
    assign unused_pk = ^pk[LEVELS];

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Front-end PC owner: issues dual-slot fetch requests, applies resolved
// redirects (live or pending), tags requests with an epoch and pulses flush.
module fetch_pc_sequencer
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_stall,
    input  logic                        redirect_valid,
    input  logic [1:0]                  redirect_ctrl,
    input  logic [31:0]                 redirect_target,
    fetch_pc_sequencer_if.master        req,
    output logic                        flush,
    output logic                        misalign_exc,
    output logic [31:0]                 misalign_addr
);
    fetch_state_t state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  req_mask_q, req_mask_d;
    logic        req_epoch_q, req_epoch_d;
    logic        epoch_q, epoch_d;
    logic        flush_q, flush_d;
    logic        mexc_q, mexc_d;
    logic [31:0] maddr_q, maddr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] seq_pc_q, seq_pc_d;

    pc_ctrl_t    ctrl;
    logic        is_jb, redir_take, redir_bad;
    logic        xfer, hold, issue;
    logic [31:0] seq_next, next_addr;
    logic        pc_carry_unused;

    assign ctrl       = pc_ctrl_t'(redirect_ctrl);
    assign is_jb      = redirect_valid && (ctrl == PC_JUMP || ctrl == PC_BRANCH);
    assign redir_take = is_jb && (redirect_target[1:0] == 2'b00);
    assign redir_bad  = is_jb && (redirect_target[1:0] != 2'b00);
    assign xfer       = req_valid_q && req.req_ready;
    assign hold       = req_valid_q && !req.req_ready;

    Kogge_Stone #(.WIDTH(32)) u_pc_add (
        .a      (req_addr_q),
        .b      (fetch_step(req_addr_q[2], FETCH_WIDTH)),
        .sub_en (1'b0),
        .sum    (seq_next),
        .cout   (pc_carry_unused)
    );

    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        req_mask_d   = req_mask_q;
        req_epoch_d  = req_epoch_q;
        epoch_d      = epoch_q ^ redir_take;
        flush_d      = redir_take;
        mexc_d       = redir_bad;
        maddr_d      = redir_bad ? redirect_target : maddr_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        seq_pc_d     = xfer ? seq_next : seq_pc_q;
        issue        = 1'b0;

        if (redir_take)        next_addr = redirect_target;
        else if (pend_valid_q) next_addr = pend_addr_q;
        else                   next_addr = seq_pc_d;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                issue   = 1'b1;
            end
            RUN, WAIT: begin
                if (hold) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                    issue   = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase

        // A redirect that cannot issue now waits in the one-entry pending slot.
        if (redir_take && (!issue || fetch_stall)) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = redirect_target;
        end

        if (issue) begin
            if (fetch_stall) begin
                req_valid_d = 1'b0;
                req_mask_d  = 2'b00;
            end else begin
                req_valid_d  = 1'b1;
                req_addr_d   = next_addr;
                req_mask_d   = fetch_mask(next_addr[2], FETCH_WIDTH);
                req_epoch_d  = epoch_d;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            req_valid_q  <= 1'b0;
            req_addr_q   <= RESET_PC;
            req_mask_q   <= 2'b00;
            req_epoch_q  <= 1'b0;
            epoch_q      <= 1'b0;
            flush_q      <= 1'b0;
            mexc_q       <= 1'b0;
            maddr_q      <= 32'h0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0;
            seq_pc_q     <= RESET_PC;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_mask_q   <= req_mask_d;
            req_epoch_q  <= req_epoch_d;
            epoch_q      <= epoch_d;
            flush_q      <= flush_d;
            mexc_q       <= mexc_d;
            maddr_q      <= maddr_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            seq_pc_q     <= seq_pc_d;
        end
    end

    assign req.req_valid     = req_valid_q;
    assign req.req_addr      = req_addr_q;
    assign req.req_slot_mask = req_mask_q;
    assign req.req_epoch     = req_epoch_q;
    assign flush             = flush_q;
    assign misalign_exc      = mexc_q;
    assign misalign_addr     = maddr_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed scenarios then random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stall;
    logic        redirect_valid;
    logic [1:0]  redirect_ctrl;
    logic [31:0] redirect_target;
    logic        flush;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    fetch_pc_sequencer_if req_if ();

    fetch_pc_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_WIDTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_stall     (fetch_stall),
        .redirect_valid  (redirect_valid),
        .redirect_ctrl   (redirect_ctrl),
        .redirect_target (redirect_target),
        .req             (req_if),
        .flush           (flush),
        .misalign_exc    (misalign_exc),
        .misalign_addr   (misalign_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the request port should show after each edge.
    bit          m_valid;
    bit [31:0]   m_addr;
    bit [1:0]    m_mask;
    bit          m_epoch_out;
    bit          m_flush;
    bit          m_mexc;
    bit [31:0]   m_maddr;
    bit          m_epoch;
    bit [31:0]   m_pc;
    bit [31:0]   m_pend[$];

    function automatic bit [31:0] m_step(input bit [31:0] a);
        return (a % 8 == 0) ? 32'd8 : 32'd4;
    endfunction

    function automatic bit [1:0] m_slots(input bit [31:0] a);
        return (a % 8 == 0) ? 2'b11 : 2'b01;
    endfunction

    task automatic model_edge();
        bit        taken, bad, rdy;
        bit [31:0] a;
        if (rst) begin
            m_valid = 0; m_addr = 32'h0; m_mask = 0; m_epoch_out = 0;
            m_flush = 0; m_mexc = 0; m_maddr = 0; m_epoch = 0;
            m_pc = 32'h0; m_pend.delete();
            return;
        end
        rdy   = req_if.req_ready;
        taken = redirect_valid && redirect_ctrl >= 2 && redirect_target % 4 == 0;
        bad   = redirect_valid && redirect_ctrl >= 2 && redirect_target % 4 != 0;
        if (m_valid && rdy) m_pc = m_addr + m_step(m_addr);
        m_flush = taken;
        m_mexc  = bad;
        if (bad) m_maddr = redirect_target;
        if (taken) m_epoch = !m_epoch;
        if (m_valid && !rdy) begin
            if (taken) begin m_pend.delete(); m_pend.push_back(redirect_target); end
        end else if (fetch_stall) begin
            m_valid = 0;
            m_mask  = 0;
            if (taken) begin m_pend.delete(); m_pend.push_back(redirect_target); end
        end else begin
            if (taken)               a = redirect_target;
            else if (m_pend.size()) a = m_pend[0];
            else                     a = m_pc;
            m_pend.delete();
            m_valid     = 1;
            m_addr      = a;
            m_mask      = m_slots(a);
            m_epoch_out = m_epoch;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(req_if.req_valid), 32'(m_valid));
        chk("addr",  req_if.req_addr, m_addr);
        chk("mask",  32'(req_if.req_slot_mask), 32'(m_mask));
        chk("epoch", 32'(req_if.req_epoch), 32'(m_epoch_out));
        chk("flush", 32'(flush), 32'(m_flush));
        chk("mexc",  32'(misalign_exc), 32'(m_mexc));
        chk("maddr", misalign_addr, m_maddr);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic redir(input logic [1:0] c, input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_ctrl   = c;
        redirect_target = t;
    endtask

    initial begin
        rst = 1'b1; fetch_stall = 1'b0; redirect_valid = 1'b0;
        redirect_ctrl = 2'b00; redirect_target = 32'h0; req_if.req_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(req_if.req_valid), 32'd0);
        chk("rst_addr",  req_if.req_addr, 32'h0);

        // Straight-line dual fetch from reset
        rst = 1'b0; req_if.req_ready = 1'b1;
        tick(); chk("t1_a0", req_if.req_addr, 32'h0);
        chk("t1_m0", 32'(req_if.req_slot_mask), 32'd3);
        tick(); chk("t1_a1", req_if.req_addr, 32'h8);
        tick(); chk("t1_a2", req_if.req_addr, 32'h10);
        chk("t1_ep", 32'(req_if.req_epoch), 32'd0);

        // Branch to 0x104: single slot then realigned dual
        redir(2'b11, 32'h104); tick(); redirect_valid = 1'b0;
        chk("t2_flush", 32'(flush), 32'd1);
        chk("t2_ep", 32'(req_if.req_epoch), 32'd1);
        chk("t2_a", req_if.req_addr, 32'h104);
        chk("t2_m", 32'(req_if.req_slot_mask), 32'd1);
        tick(); chk("t2_a2", req_if.req_addr, 32'h108);
        chk("t2_m2", 32'(req_if.req_slot_mask), 32'd3);

        // IMEM backpressure at 0x20 with redirect captured as pending
        redir(2'b10, 32'h20); tick(); redirect_valid = 1'b0;
        req_if.req_ready = 1'b0; tick();
        redir(2'b11, 32'h400); tick(); redirect_valid = 1'b0;
        chk("t3_hold_a", req_if.req_addr, 32'h20);
        chk("t3_hold_ep", 32'(req_if.req_epoch), 32'd0);
        chk("t3_flush", 32'(flush), 32'd1);
        tick(); chk("t3_hold_a2", req_if.req_addr, 32'h20);
        req_if.req_ready = 1'b1; tick();
        chk("t3_pend_a", req_if.req_addr, 32'h400);
        chk("t3_pend_ep", 32'(req_if.req_epoch), 32'd1);

        // Misaligned jump target
        redir(2'b10, 32'h102); tick(); redirect_valid = 1'b0;
        chk("t4_flush", 32'(flush), 32'd0);
        chk("t4_mexc", 32'(misalign_exc), 32'd1);
        chk("t4_maddr", misalign_addr, 32'h102);
        chk("t4_a", req_if.req_addr, 32'h408);
        tick(); chk("t4_mexc_off", 32'(misalign_exc), 32'd0);
        chk("t4_maddr_hold", misalign_addr, 32'h102);

        // Address wrap and ignored normal control
        redir(2'b11, 32'hFFFF_FFF8); tick(); redirect_valid = 1'b0;
        chk("t5_top", req_if.req_addr, 32'hFFFF_FFF8);
        tick(); chk("t5_wrap", req_if.req_addr, 32'h0);
        redir(2'b01, 32'h500); tick(); redirect_valid = 1'b0;
        chk("t5_ign_a", req_if.req_addr, 32'h8);
        chk("t5_ign_fl", 32'(flush), 32'd0);

        // Reset while waiting with a pending redirect
        req_if.req_ready = 1'b0; tick();
        redir(2'b11, 32'h600); tick(); redirect_valid = 1'b0;
        rst = 1'b1; tick();
        chk("t6_valid", 32'(req_if.req_valid), 32'd0);
        rst = 1'b0; req_if.req_ready = 1'b1; tick();
        chk("t6_a", req_if.req_addr, 32'h0);
        chk("t6_ep", 32'(req_if.req_epoch), 32'd0);
        chk("t6_v", 32'(req_if.req_valid), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom_range(0, 79) == 0);
            fetch_stall      = ($urandom_range(0, 3) == 0);
            req_if.req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid   = ($urandom_range(0, 3) == 0);
            redirect_ctrl    = 2'($urandom_range(0, 3));
            redirect_target  = $urandom();
            if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
